// File: rtl/vote_pkg.sv
// vote_pkg
//   Shared definitions for the vote result UART transmitter.
//   - VOTE_W, NUM_CAND, FRAME_BYTES: vote width, candidate count, bytes per frame
//   - HEADER_DEFAULT: default first byte of every frame
//   - frame_state_t: frame-level FSM (IDLE / SEND / DONE), owned by the top
//   - byte_state_t: per-byte serializer FSM (IDLE / START / DATA / STOP)
//   - checksum(): modulo-256 sum of the four totals
package vote_pkg;

    localparam int VOTE_W      = 8;
    localparam int NUM_CAND    = 4;
    localparam int FRAME_BYTES = 6;

    localparam logic [VOTE_W-1:0] HEADER_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        FRAME_IDLE,
        FRAME_SEND,
        FRAME_DONE
    } frame_state_t;

    typedef enum logic [1:0] {
        BIT_IDLE,
        BIT_START,
        BIT_DATA,
        BIT_STOP
    } byte_state_t;

    // The sum is evaluated at VOTE_W bits, so overflow simply wraps.
    function automatic logic [VOTE_W-1:0] checksum(
        input logic [VOTE_W-1:0] c0,
        input logic [VOTE_W-1:0] c1,
        input logic [VOTE_W-1:0] c2,
        input logic [VOTE_W-1:0] c3
    );
        return c0 + c1 + c2 + c3;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte
//   Serializes one byte as 8N1, LSB first: start bit, d0..d7, stop bit,
//   each lasting CLKS_PER_BIT cycles. Owns the bit timer and bit index.
//   Ports:
//   - clock, reset : system clock, synchronous active-high reset
//   - start        : load data_byte; accepted in IDLE or in the last stop-bit cycle
//   - data_byte    : byte to send, sampled when start is accepted
//   - tx           : serial line (registered), idles high
//   - byte_done    : high during the last cycle of the stop bit
module uart_tx_byte
    import vote_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [VOTE_W-1:0] data_byte,
    output logic              tx,
    output logic              byte_done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

    byte_state_t       state;
    logic [TW-1:0]     timer;
    logic [2:0]        bit_idx;
    logic [VOTE_W-1:0] shreg;
    logic              timer_wrap;

    assign timer_wrap = (timer == TIMER_LAST);

    // Asserted in the final stop-bit cycle so the parent can hand over the
    // next byte in time for its start bit to follow with no idle gap.
    assign byte_done = (state == BIT_STOP) && timer_wrap;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= BIT_IDLE;
            tx      <= 1'b1;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                BIT_IDLE: begin
                    timer   <= '0;
                    bit_idx <= '0;
                    if (start) begin
                        shreg <= data_byte;
                        tx    <= 1'b0;
                        state <= BIT_START;
                    end else begin
                        tx <= 1'b1;
                    end
                end
                BIT_START: begin
                    if (timer_wrap) begin
                        timer <= '0;
                        tx    <= shreg[0];
                        state <= BIT_DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                BIT_DATA: begin
                    if (timer_wrap) begin
                        timer <= '0;
                        // shreg[0] is the bit currently on the line, so the
                        // next data bit is always shreg[1] before the shift.
                        shreg <= shreg >> 1;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            tx      <= 1'b1;
                            state   <= BIT_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                BIT_STOP: begin
                    if (timer_wrap) begin
                        timer <= '0;
                        if (start) begin
                            shreg <= data_byte;
                            tx    <= 1'b0;
                            state <= BIT_START;
                        end else begin
                            tx    <= 1'b1;
                            state <= BIT_IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    timer <= '0;
                    state <= BIT_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/vote_result_uart_tx.sv
// vote_result_uart_tx
//   Sends the four candidate vote totals as one UART frame:
//   HEADER_BYTE, cnt0, cnt1, cnt2, cnt3, checksum (sum mod 256).
//   A request is taken only in result mode and only when no frame is in
//   flight; the totals are snapshotted at that moment.
//   Ports:
//   - clock, reset          : system clock, synchronous active-high reset
//   - mode                  : 1 = result mode (sending allowed)
//   - send_req              : one-cycle request to transmit
//   - cand_vote_recvd0..3   : candidate vote totals
//   - tx                    : UART serial line, idles high
//   - busy                  : high while a frame is in flight
//   - done                  : one-cycle pulse after the final stop bit
module vote_result_uart_tx
    import vote_pkg::*;
#(
    parameter int                CLKS_PER_BIT = 434,
    parameter logic [VOTE_W-1:0] HEADER_BYTE  = HEADER_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mode,
    input  logic              send_req,
    input  logic [VOTE_W-1:0] cand_vote_recvd0,
    input  logic [VOTE_W-1:0] cand_vote_recvd1,
    input  logic [VOTE_W-1:0] cand_vote_recvd2,
    input  logic [VOTE_W-1:0] cand_vote_recvd3,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

    frame_state_t      state;
    logic [VOTE_W-1:0] snap [NUM_CAND];
    logic [VOTE_W-1:0] chk;
    logic [2:0]        byte_idx;
    logic [2:0]        next_idx;
    logic              accept;
    logic              byte_start;
    logic              byte_done;
    logic [VOTE_W-1:0] byte_data;

    // The DONE cycle already counts as idle for acceptance, which is what
    // lets a second frame follow immediately after the done pulse.
    assign accept = send_req && mode &&
                    ((state == FRAME_IDLE) || (state == FRAME_DONE));

    // The next byte is handed to the serializer in the same cycle the
    // current one reports byte_done, keeping bytes back to back.
    always_comb begin
        next_idx   = byte_idx + 3'd1;
        byte_start = accept ||
                     ((state == FRAME_SEND) && byte_done && (byte_idx != LAST_IDX));
        byte_data  = HEADER_BYTE;
        if (!accept) begin
            case (next_idx)
                3'd1:    byte_data = snap[0];
                3'd2:    byte_data = snap[1];
                3'd3:    byte_data = snap[2];
                3'd4:    byte_data = snap[3];
                3'd5:    byte_data = chk;
                default: byte_data = HEADER_BYTE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= FRAME_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            byte_idx <= '0;
            chk      <= '0;
            for (int i = 0; i < NUM_CAND; i++) begin
                snap[i] <= '0;
            end
        end else begin
            case (state)
                FRAME_IDLE, FRAME_DONE: begin
                    done <= 1'b0;
                    if (accept) begin
                        snap[0]  <= cand_vote_recvd0;
                        snap[1]  <= cand_vote_recvd1;
                        snap[2]  <= cand_vote_recvd2;
                        snap[3]  <= cand_vote_recvd3;
                        chk      <= checksum(cand_vote_recvd0, cand_vote_recvd1,
                                             cand_vote_recvd2, cand_vote_recvd3);
                        byte_idx <= '0;
                        busy     <= 1'b1;
                        state    <= FRAME_SEND;
                    end else begin
                        state <= FRAME_IDLE;
                    end
                end
                FRAME_SEND: begin
                    if (byte_done) begin
                        if (byte_idx == LAST_IDX) begin
                            byte_idx <= '0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= FRAME_DONE;
                        end else begin
                            byte_idx <= next_idx;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= FRAME_IDLE;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .clock     (clock),
        .reset     (reset),
        .start     (byte_start),
        .data_byte (byte_data),
        .tx        (tx),
        .byte_done (byte_done)
    );

endmodule

// File: tb/tb_vote_result_uart_tx.sv
// tb_vote_result_uart_tx
//   Self-checking bench for vote_result_uart_tx with CLKS_PER_BIT=4.
//   Expected line waveforms come from a frame model: the byte list
//   (header, totals, sum mod 256) expanded into start/data/stop bit slots.
module tb_vote_result_uart_tx;

    localparam int C     = 4;
    localparam int FRAME = 60 * C;

    logic       clock = 1'b0;
    logic       reset;
    logic       mode;
    logic       send_req;
    logic [7:0] c0, c1, c2, c3;
    logic       tx, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    logic cap_tx   [0:511];
    logic cap_busy [0:511];
    logic cap_done [0:511];
    int   first_low, busy_cnt, done_cnt, done_at;
    int   exp_bytes [6];
    logic [7:0] saved [6];

    always #5 clock = ~clock;

    vote_result_uart_tx #(
        .CLKS_PER_BIT (C),
        .HEADER_BYTE  (8'hA5)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .mode             (mode),
        .send_req         (send_req),
        .cand_vote_recvd0 (c0),
        .cand_vote_recvd1 (c1),
        .cand_vote_recvd2 (c2),
        .cand_vote_recvd3 (c3),
        .tx               (tx),
        .busy             (busy),
        .done             (done)
    );

    // Frame model: header, the four totals, then their sum modulo 256.
    function automatic void set_expected(input int a, input int b, input int c, input int d);
        exp_bytes[0] = 165;
        exp_bytes[1] = a;
        exp_bytes[2] = b;
        exp_bytes[3] = c;
        exp_bytes[4] = d;
        exp_bytes[5] = (a + b + c + d) % 256;
    endfunction

    // Expected line level k cycles after the accept cycle.
    function automatic logic exp_line(input int k);
        int pos, byt, slot;
        if (k < 1 || k > FRAME) return 1'b1;
        pos  = k - 1;
        byt  = pos / (10 * C);
        slot = (pos % (10 * C)) / C;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return ((exp_bytes[byt] >> (slot - 1)) % 2) == 1;
    endfunction

    function automatic int wave_errs(input int len);
        int e = 0;
        for (int k = 1; k <= len; k++) begin
            if (cap_tx[k] !== exp_line(k)) e++;
        end
        return e;
    endfunction

    // Recover byte b of a captured frame by sampling mid-bit.
    function automatic logic [7:0] decode(input int b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = cap_tx[1 + b * 10 * C + (i + 1) * C + C / 2];
        end
        return r;
    endfunction

    task automatic request(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        @(negedge clock);
        c0 = a; c1 = b; c2 = c; c3 = d;
        mode     = 1'b1;
        send_req = 1'b1;
        set_expected(int'(a), int'(b), int'(c), int'(d));
    endtask

    // Records len cycles after the request cycle and drives mid-frame events.
    task automatic capture(input int len, input int hold_req, input int pulse_at,
                           input int zero_at, input int modelow_at, input int reset_at);
        first_low = -1; busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int k = 1; k <= len; k++) begin
            @(negedge clock);
            cap_tx[k]   = tx;
            cap_busy[k] = busy;
            cap_done[k] = done;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (tx === 1'b0 && first_low < 0) first_low = k;
            send_req = (k < hold_req) || (k == pulse_at);
            if (k == zero_at) begin
                c0 = 8'h00; c1 = 8'h00; c2 = 8'h00; c3 = 8'h00;
            end
            if (k == modelow_at) mode = 1'b0;
            reset = (k == reset_at);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            n_checks++;
            if (tx !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_tx cycle %0d: got %b expected 1", i, tx); end
            n_checks++;
            if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy cycle %0d: got %b expected 0", i, busy); end
            n_checks++;
            if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done cycle %0d: got %b expected 0", i, done); end
        end
    endtask

    task automatic test_basic_frame;
        int e;
        request(8'd3, 8'd1, 8'd0, 8'd7);
        capture(250, 1, -1, -1, -1, -1);
        n_checks++;
        if (first_low !== 1) begin n_fail++; $display("[TB] FAIL basic_first_low: got %0d expected 1", first_low); end
        n_checks++;
        if (done_at !== FRAME + 1) begin n_fail++; $display("[TB] FAIL basic_done_at: got %0d expected %0d", done_at, FRAME + 1); end
        n_checks++;
        if (done_cnt !== 1) begin n_fail++; $display("[TB] FAIL basic_done_cnt: got %0d expected 1", done_cnt); end
        n_checks++;
        if (busy_cnt !== FRAME) begin n_fail++; $display("[TB] FAIL basic_busy_cnt: got %0d expected %0d", busy_cnt, FRAME); end
        n_checks++;
        if (cap_busy[FRAME] !== 1'b1 || cap_busy[FRAME + 1] !== 1'b0) begin
            n_fail++; $display("[TB] FAIL basic_busy_edge: got %b%b expected 10", cap_busy[FRAME], cap_busy[FRAME + 1]);
        end
        e = wave_errs(250);
        n_checks++;
        if (e !== 0) begin n_fail++; $display("[TB] FAIL basic_wave: got %0d bad cycles expected 0", e); end
        for (int b = 0; b < 6; b++) begin
            n_checks++;
            if (decode(b) !== 8'(exp_bytes[b])) begin
                n_fail++; $display("[TB] FAIL basic_byte%0d: got %h expected %h", b, decode(b), 8'(exp_bytes[b]));
            end
        end
    endtask

    task automatic test_checksum_wrap;
        int e;
        request(8'hFF, 8'hFF, 8'h02, 8'h00);
        capture(250, 1, -1, 30, 120, -1);
        mode = 1'b1;
        e = wave_errs(250);
        n_checks++;
        if (e !== 0) begin n_fail++; $display("[TB] FAIL wrap_wave: got %0d bad cycles expected 0", e); end
        for (int b = 1; b < 6; b++) begin
            n_checks++;
            if (decode(b) !== 8'(exp_bytes[b])) begin
                n_fail++; $display("[TB] FAIL wrap_byte%0d: got %h expected %h", b, decode(b), 8'(exp_bytes[b]));
            end
        end
        n_checks++;
        if (done_at !== FRAME + 1) begin n_fail++; $display("[TB] FAIL wrap_done_at: got %0d expected %0d", done_at, FRAME + 1); end
    endtask

    task automatic test_request_filter;
        int bad = 0;
        int e;
        @(negedge clock);
        mode = 1'b0; send_req = 1'b1;
        c0 = 8'($urandom_range(255)); c1 = 8'($urandom_range(255));
        @(negedge clock);
        send_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("[TB] FAIL mode0_idle: got %0d active cycles expected 0", bad); end
        request(8'($urandom_range(255)), 8'($urandom_range(255)),
                8'($urandom_range(255)), 8'($urandom_range(255)));
        capture(260, 1, 50, -1, -1, -1);
        n_checks++;
        if (done_cnt !== 1) begin n_fail++; $display("[TB] FAIL busy_req_done_cnt: got %0d expected 1", done_cnt); end
        n_checks++;
        if (done_at !== FRAME + 1) begin n_fail++; $display("[TB] FAIL busy_req_done_at: got %0d expected %0d", done_at, FRAME + 1); end
        n_checks++;
        if (busy_cnt !== FRAME) begin n_fail++; $display("[TB] FAIL busy_req_busy_cnt: got %0d expected %0d", busy_cnt, FRAME); end
        e = wave_errs(260);
        n_checks++;
        if (e !== 0) begin n_fail++; $display("[TB] FAIL busy_req_wave: got %0d bad cycles expected 0", e); end
    endtask

    task automatic test_reset_abort;
        int bad = 0;
        int e;
        request(8'($urandom_range(255)), 8'($urandom_range(255)),
                8'($urandom_range(255)), 8'($urandom_range(255)));
        capture(260, 1, -1, -1, -1, 100);
        n_checks++;
        if (cap_tx[101] !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_tx: got %b expected 1", cap_tx[101]); end
        n_checks++;
        if (cap_busy[101] !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_busy: got %b expected 0", cap_busy[101]); end
        n_checks++;
        if (done_cnt !== 0) begin n_fail++; $display("[TB] FAIL abort_done: got %0d pulses expected 0", done_cnt); end
        for (int k = 101; k <= 260; k++) begin
            if (cap_tx[k] !== 1'b1 || cap_busy[k] !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("[TB] FAIL abort_idle: got %0d active cycles expected 0", bad); end
        request(8'($urandom_range(255)), 8'($urandom_range(255)),
                8'($urandom_range(255)), 8'($urandom_range(255)));
        capture(250, 1, -1, -1, -1, -1);
        e = wave_errs(250);
        n_checks++;
        if (e !== 0) begin n_fail++; $display("[TB] FAIL abort_next_wave: got %0d bad cycles expected 0", e); end
        n_checks++;
        if (done_at !== FRAME + 1) begin n_fail++; $display("[TB] FAIL abort_next_done_at: got %0d expected %0d", done_at, FRAME + 1); end
    endtask

    task automatic test_back_to_back;
        int e;
        request(8'($urandom_range(255)), 8'($urandom_range(255)),
                8'($urandom_range(255)), 8'($urandom_range(255)));
        capture(FRAME + 1, FRAME + 2, -1, -1, -1, -1);
        n_checks++;
        if (done_at !== FRAME + 1) begin n_fail++; $display("[TB] FAIL b2b_first_done_at: got %0d expected %0d", done_at, FRAME + 1); end
        e = wave_errs(FRAME + 1);
        n_checks++;
        if (e !== 0) begin n_fail++; $display("[TB] FAIL b2b_first_wave: got %0d bad cycles expected 0", e); end
        for (int b = 0; b < 6; b++) saved[b] = decode(b);
        capture(250, 1, -1, -1, -1, -1);
        n_checks++;
        if (first_low !== 1) begin n_fail++; $display("[TB] FAIL b2b_second_start: got %0d expected 1", first_low); end
        n_checks++;
        if (done_at !== FRAME + 1) begin n_fail++; $display("[TB] FAIL b2b_second_done_at: got %0d expected %0d", done_at, FRAME + 1); end
        e = wave_errs(250);
        n_checks++;
        if (e !== 0) begin n_fail++; $display("[TB] FAIL b2b_second_wave: got %0d bad cycles expected 0", e); end
        for (int b = 0; b < 6; b++) begin
            n_checks++;
            if (decode(b) !== saved[b]) begin
                n_fail++; $display("[TB] FAIL b2b_same_byte%0d: got %h expected %h", b, decode(b), saved[b]);
            end
        end
    endtask

    task automatic test_random_frames;
        int e;
        for (int it = 0; it < 3; it++) begin
            request(8'($urandom_range(255)), 8'($urandom_range(255)),
                    8'($urandom_range(255)), 8'($urandom_range(255)));
            capture(250, 1, -1, int'($urandom_range(200, 2)), -1, -1);
            e = wave_errs(250);
            n_checks++;
            if (e !== 0) begin n_fail++; $display("[TB] FAIL rand%0d_wave: got %0d bad cycles expected 0", it, e); end
            n_checks++;
            if (done_at !== FRAME + 1) begin n_fail++; $display("[TB] FAIL rand%0d_done_at: got %0d expected %0d", it, done_at, FRAME + 1); end
        end
    endtask

    initial begin
        reset    = 1'b1;
        mode     = 1'b0;
        send_req = 1'b0;
        c0 = 8'h00; c1 = 8'h00; c2 = 8'h00; c3 = 8'h00;
        test_reset();
        test_basic_frame();
        test_checksum_wrap();
        test_request_filter();
        test_reset_abort();
        test_back_to_back();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
